// File: rtl/fetch_unit.sv
// Purpose : rv32i fetch stage; PC register, ROM address drive, 2-entry {inst,pc,fault} buffer to decode.
// Latency : first fetched word valid one cycle after the push edge; redirect/trap target visible two cycles later.
// Backpr. : valid/ready to decode; when the buffer is full and not popped, the PC and the ROM address hold.
// Ports   : clk/rst (sync, active-high); imem_addr -> ROM, imem_rd <- ROM (combinational);
//           redirect_valid/redirect_pc and trap_valid/trap_pc flush and retarget (trap has priority);
//           inst_valid/inst_ready handshake carrying inst, inst_pc, inst_fault.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          IMEM_WORDS = 128,
  parameter logic [31:0] NOP        = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [15:0] trap_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [15:0] inst_pc,
  output logic        inst_fault
);

  typedef struct packed {
    logic [31:0] inst;
    logic [15:0] pc;
    logic        fault;
  } entry_t;

  // 17 bits so that a fully populated 64 KiB ROM still has a representable limit.
  localparam logic [16:0] PC_LIMIT = 17'(IMEM_WORDS * 4);

  logic [15:0] pc_q, pc_d;
  entry_t      ent_q [2];
  entry_t      ent_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;

  logic        pop;
  logic        push;
  logic        flush;
  logic        fetch_fault;
  logic [15:0] target;
  entry_t      head_ent;

  always_comb begin
    pop         = (cnt_q != 2'd0) & inst_ready;
    flush       = trap_valid | redirect_valid;
    target      = trap_valid ? trap_pc : redirect_pc;
    fetch_fault = (pc_q[1:0] != 2'b00) | ({1'b0, pc_q} >= PC_LIMIT);
    // A pop frees a slot in the same edge, so a full buffer keeps streaming.
    push        = ~flush & ((cnt_q < 2'd2) | pop);

    pc_d   = pc_q;
    ent_d  = ent_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;

    if (flush) begin
      // Anything popped this cycle was still delivered; the rest is discarded.
      pc_d   = target;
      cnt_d  = 2'd0;
      head_d = 1'b0;
      tail_d = 1'b0;
    end else begin
      if (push) begin
        ent_d[tail_q] = '{inst:  fetch_fault ? NOP : imem_rd,
                          pc:    pc_q,
                          fault: fetch_fault};
        tail_d = ~tail_q;
        pc_d   = pc_q + 16'd4;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      cnt_q    <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      ent_q  <= ent_d;
    end
  end

  always_comb begin
    head_ent   = ent_q[head_q];
    imem_addr  = pc_q;
    inst_valid = (cnt_q != 2'd0);
    inst       = inst_valid ? head_ent.inst  : NOP;
    inst_pc    = inst_valid ? head_ent.pc    : 16'h0000;
    inst_fault = inst_valid ? head_ent.fault : 1'b0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        trap_valid;
  logic [15:0] trap_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic        inst_fault;

  always #5 clk = ~clk;

  logic [31:0] rom [128];

  // Out-of-range reads return garbage so NOP substitution is observable.
  assign imem_rd = (imem_addr < 16'h0200) ? rom[imem_addr[8:2]] : 32'hDEAD_BEEF;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        tv;
    logic [15:0] tpc;
    logic        ev;
    logic [15:0] epc;
    logic        ef;
    logic [15:0] eaddr;
  } vec_t;

  vec_t        vecs [$];
  vec_t        exp_q [$];
  logic [15:0] pc_sb [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic d, input logic v, input logic [15:0] rp,
                     input logic t, input logic [15:0] tp,
                     input logic ev, input logic [15:0] epc, input logic ef,
                     input logic [15:0] ea);
    vec_t x;
    x.rst = r;  x.rdy = d;  x.rv = v;  x.rpc = rp;  x.tv = t;  x.tpc = tp;
    x.ev = ev;  x.epc = epc;  x.ef = ef;  x.eaddr = ea;
    vecs.push_back(x);
  endtask

  function automatic logic [31:0] exp_inst(input vec_t v);
    if (!v.ev || v.ef) return NOP;
    return rom[v.epc[8:2]];
  endfunction

  initial begin
    vec_t        e;
    logic [15:0] p;
    logic [31:0] prev_inst;
    logic [15:0] prev_pc;
    logic        prev_stall;
    int          budget;

    for (int i = 0; i < 128; i++) rom[i] = 32'hC000_0000 | 32'(i);
    rom[0]  = 32'h1000_0293;
    rom[1]  = 32'h0052_9073;
    rom[2]  = 32'h0000_e073;
    rom[3]  = 32'h0040_e073;
    rom[6]  = 32'h0073_0663;
    rom[50] = 32'h0420_2573;

    rst = 1'b1;  inst_ready = 1'b0;
    redirect_valid = 1'b0;  redirect_pc = 16'h0;
    trap_valid = 1'b0;  trap_pc = 16'h0;
    repeat (2) @(posedge clk);

    //   rst rdy rv rpc       tv tpc      ev epc       ef addr
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000); // reset state
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0004);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 16'h0008);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 0, 16'h000C);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h000C, 0, 16'h0010);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, 16'h0014);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000); // ready low x5
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0004);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0008);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0008);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0008);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0008); // full + pop
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 16'h000C);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 0, 16'h0010);
    add(0, 0, 1, 16'h0018, 0, 16'h0000, 1, 16'h0008, 0, 16'h0010); // redirect, full
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0018);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0018, 0, 16'h001C);
    add(0, 1, 1, 16'h0020, 1, 16'h00C8, 1, 16'h001C, 0, 16'h0020); // trap wins
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h00C8);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h00C8, 0, 16'h00CC);
    add(0, 1, 1, 16'h0006, 0, 16'h0000, 1, 16'h00CC, 0, 16'h00D0); // misaligned
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0006);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 1, 16'h000A);
    add(0, 1, 1, 16'h01FC, 0, 16'h0000, 1, 16'h000A, 1, 16'h000E); // last word
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h01FC);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h01FC, 0, 16'h0200);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 1, 16'h0204);
    add(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 1, 16'h0208);
    add(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0200, 1, 16'h0208); // mid-stream reset
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0004);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 16'h0008);
    add(0, 1, 1, 16'h0040, 0, 16'h0000, 1, 16'h0008, 0, 16'h000C); // held redirect
    add(0, 1, 1, 16'h0044, 0, 16'h0000, 0, 16'h0000, 0, 16'h0040);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0044);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0044, 0, 16'h0048);
    add(0, 1, 1, 16'hFFFC, 0, 16'h0000, 1, 16'h0048, 0, 16'h004C); // pc wrap
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFC);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFC, 1, 16'h0000);
    add(0, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0004);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(posedge clk);
      #1;
      rst            = vecs[i].rst;
      inst_ready     = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      trap_valid     = vecs[i].tv;
      trap_pc        = vecs[i].tpc;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(e.ev));
      chk($sformatf("row%0d inst", i), inst, exp_inst(e));
      chk($sformatf("row%0d inst_pc", i), 32'(inst_pc), e.ev ? 32'(e.epc) : 32'h0);
      chk($sformatf("row%0d inst_fault", i), 32'(inst_fault), 32'(e.ev & e.ef));
      chk($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(e.eaddr));
    end

    // Random back-pressure stream: every word from 0x100 must arrive once, in order.
    @(posedge clk); #1;
    rst = 1'b0;  inst_ready = 1'b0;  trap_valid = 1'b0;
    redirect_valid = 1'b1;  redirect_pc = 16'h0100;
    for (int k = 0; k < 30; k++) pc_sb.push_back(16'h0100 + 16'(4 * k));
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    prev_stall = 1'b0;  prev_inst = '0;  prev_pc = '0;  budget = 0;
    while (pc_sb.size() > 0 && budget < 300) begin
      inst_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (prev_stall) begin
        chk("stall hold inst", inst, prev_inst);
        chk("stall hold inst_pc", 32'(inst_pc), 32'(prev_pc));
      end
      if (inst_valid && inst_ready) begin
        p = pc_sb.pop_front();
        chk("stream inst_pc", 32'(inst_pc), 32'(p));
        chk("stream inst", inst, rom[p[8:2]]);
      end
      prev_stall = inst_valid && !inst_ready;
      prev_inst  = inst;
      prev_pc    = inst_pc;
      budget++;
      @(posedge clk); #1;
    end
    inst_ready = 1'b0;
    checks++;
    if (pc_sb.size() != 0) begin
      errors++;
      $display("FAIL stream timeout: %0d words outstanding, required 0", pc_sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the rv32i core. Holds the program counter, drives the byte address into the combinational instruction ROM, and captures each returned word with its PC into a 2-entry buffer. The buffer feeds decode through a valid/ready handshake. Branch/jump redirects and trap/return vectors from the execute stage and CSR unit flush the buffer and restart fetch at the new target.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC loaded on reset
- IMEM_WORDS, 128, number of 32-bit words implemented in the ROM; addresses at or beyond IMEM_WORDS*4 are faults
- NOP, 32'h00000013, instruction presented while the buffer is empty or an entry is faulted

Ports:
- clk, in, 1, single clock; all state updates on the rising edge
- rst, in, 1, synchronous, active-high reset
- imem_addr, out, 16, byte address to the ROM; always equals the current pc
- imem_rd, in, 32, ROM read data; combinational from imem_addr, same cycle
- redirect_valid, in, 1, branch/jal/jalr taken this cycle
- redirect_pc, in, 16, redirect target
- trap_valid, in, 1, trap entry or uret this cycle (CSR unit supplies the vector or the saved return PC)
- trap_pc, in, 16, trap/return target
- inst_valid, out, 1, buffer head is valid
- inst_ready, in, 1, decode accepts the head
- inst, out, 32, head instruction
- inst_pc, out, 16, PC of the head
- inst_fault, out, 1, head is a fetch fault (misaligned or out of range); in that case inst = NOP

## Operation
- State: pc[15:0]; buffer of 2 entries {inst, pc, fault}; 2-bit count (0..2); head/tail pointers.
- pop = inst_valid & inst_ready. flush = trap_valid | redirect_valid.
- Target: if trap_valid, the target is trap_pc. Otherwise, if redirect_valid, the target is redirect_pc. Trap wins when both are asserted.
- Flush cycle:
  - At the edge: pc <= target; count <= 0; no push.
  - A pop in the same cycle still counts as delivered to decode.
- Normal cycle (no flush), with push = (count < 2) | pop:
  - On push: write {imem_rd or NOP, pc, fault} at the tail, then pc <= pc + 4.
  - fault = (pc[1:0] != 0) | (pc >= IMEM_WORDS*4). A faulted entry carries inst = NOP and fault = 1.
  - Fetch continues past a fault; decode or the trap logic decides what to do with it.
- Count update: count <= count + push - pop.
- Full buffer (count = 2, no pop): pc holds, imem_addr holds, no push.
- Empty buffer: inst_valid = 0, inst = NOP, inst_pc = 0, inst_fault = 0.
- Pointer and PC widths:
  - pc + 4 is 16-bit modulo; 16'hFFFC wraps to 16'h0000.
  - Pointers are 1-bit and wrap naturally.

## Timing
- Reset (rst high at an edge) values:
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - count = 0, so inst_valid = 0, inst = NOP, inst_pc = 0, inst_fault = 0.
- Reset mid-operation discards all entries and any pending redirect.
- Start-up: first edge with rst low pushes RESET_PC. inst_valid = 1 in the following cycle.
- Sustained throughput is 1 instruction/cycle while inst_ready = 1.
- Redirect latency: redirect/trap asserted in cycle N gives:
  - cycle N+1: inst_valid = 0, imem_addr = target.
  - cycle N+2: inst_valid = 1, inst_pc = target.
- Back-pressure: while inst_valid = 1 and inst_ready = 0, inst, inst_pc and inst_fault stay stable. Only flush or rst may change them.
- Full with pop in the same cycle: push and pop both occur and count stays at 2, so there is no bubble.
- redirect_valid held for several cycles: each cycle reloads the target and keeps the buffer empty.

## Test plan
- Reset release with ROM[0..3] = 10000293, 00529073, 0000e073, 0040e073 and inst_ready = 1:
  - first edge after rst low pushes pc 0; one cycle later inst_valid = 1 with inst_pc 0, then 4, 8, 12 on consecutive cycles, inst matching ROM.
- inst_ready = 0 for 5 cycles from reset:
  - count saturates at 2 and imem_addr stops at 8.
  - inst = 10000293 at pc 0 stays stable.
  - releasing ready yields pcs 0, 4, 8 with no gap or duplicate.
- redirect_valid with redirect_pc = 16'h0018 while 2 entries are buffered:
  - next cycle inst_valid = 0.
  - the cycle after: inst_pc = 0x18, inst = ROM[6] = 00730663.
- trap_valid with trap_pc = 0x00C8, redirect_valid with redirect_pc = 0x0020, same cycle:
  - the trap wins; inst_pc = 0x00C8 and inst = ROM[50] = 04202573 two cycles later.
- redirect to 0x0006 gives inst_fault = 1, inst = 00000013, inst_pc = 6.
- redirect to 0x01FC (last word):
  - 0x01FC is fetched normally.
  - 0x0200 is faulted with inst = 00000013.
- rst asserted for 1 cycle mid-stream with 2 entries buffered:
  - next cycle inst_valid = 0 and imem_addr = RESET_PC.
  - the stream restarts at pc 0.
